// File: rtl/eight_way_result_demux.sv
// Write-side result demux: steers one tagged result per cycle into one of eight holding registers
// with per-channel valid/ack handshakes. Define DEMUX_BROADCAST_EN to add the bcast_i port.
module eight_way_result_demux #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [2:0]                  sel_i,
    input  logic [WIDTH-1:0]            in_data_i,
`ifdef DEMUX_BROADCAST_EN
    input  logic                        bcast_i,
`endif
    output logic [CHANNELS*WIDTH-1:0]   ch_data_o,
    output logic [CHANNELS-1:0]         ch_valid_o,
    input  logic [CHANNELS-1:0]         ch_ack_i,
    output logic [3:0]                  occupancy_o,
    output logic [15:0]                 wr_count_o
);

    logic [CHANNELS*WIDTH-1:0] ch_data_q, ch_data_d;
    logic [CHANNELS-1:0]       ch_valid_q, ch_valid_d;
    logic [3:0]                occupancy_q, occupancy_d;
    logic [15:0]               wr_count_q, wr_count_d;
    logic [CHANNELS-1:0]       ack_eff;
    logic                      bcast;
    logic                      accept;

`ifdef DEMUX_BROADCAST_EN
    assign bcast = bcast_i;
`else
    assign bcast = 1'b0;
`endif

    // Ready looks only at registered flags, so an ack never frees a channel in the same cycle.
    assign in_ready_o = bcast ? (ch_valid_q == '0) : ~ch_valid_q[sel_i];
    assign accept     = in_valid_i & in_ready_o;
    assign ack_eff    = ch_ack_i & ch_valid_q;

    always_comb begin
        ch_data_d   = ch_data_q;
        ch_valid_d  = ch_valid_q & ~ack_eff;
        wr_count_d  = wr_count_q;
        occupancy_d = '0;
        if (accept) begin
            wr_count_d = wr_count_q + 16'd1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (bcast || (sel_i == i[2:0])) begin
                    ch_valid_d[i]                = 1'b1;
                    ch_data_d[i*WIDTH +: WIDTH]  = in_data_i;
                end
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            occupancy_d = occupancy_d + {3'b000, ch_valid_d[i]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ch_data_q   <= '0;
            ch_valid_q  <= '0;
            occupancy_q <= '0;
            wr_count_q  <= '0;
        end else begin
            ch_data_q   <= ch_data_d;
            ch_valid_q  <= ch_valid_d;
            occupancy_q <= occupancy_d;
            wr_count_q  <= wr_count_d;
        end
    end

    assign ch_data_o   = ch_data_q;
    assign ch_valid_o  = ch_valid_q;
    assign occupancy_o = occupancy_q;
    assign wr_count_o  = wr_count_q;

endmodule

// File: tb/tb_eight_way_result_demux.sv
// Randomized and directed bench for eight_way_result_demux against an array-based channel model.
module tb_eight_way_result_demux;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    sel;
    logic [W-1:0]  in_data;
    logic          bcast;
    logic [8*W-1:0] ch_data;
    logic [7:0]    ch_valid;
    logic [7:0]    ch_ack;
    logic [3:0]    occupancy;
    logic [15:0]   wr_count;

    always #5 clk = ~clk;

    eight_way_result_demux #(.WIDTH(W), .CHANNELS(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sel_i       (sel),
        .in_data_i   (in_data),
`ifdef DEMUX_BROADCAST_EN
        .bcast_i     (bcast),
`endif
        .ch_data_o   (ch_data),
        .ch_valid_o  (ch_valid),
        .ch_ack_i    (ch_ack),
        .occupancy_o (occupancy),
        .wr_count_o  (wr_count)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_data [8];
    bit          m_full [8];
    int          m_writes;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_valid_vec();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v[i] = m_full[i];
        return v;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_full[i]);
        return n;
    endfunction

    function automatic bit m_ready(input logic [2:0] s, input bit bc);
        if (bc) return m_occ() == 0;
        return !m_full[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i] = '0;
            m_full[i] = 1'b0;
        end
        m_writes = 0;
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".valid"}, 32'(ch_valid), 32'(m_valid_vec()));
        check_eq({tag, ".occ"}, 32'(occupancy), 32'(m_occ()));
        check_eq({tag, ".wrcnt"}, 32'(wr_count), m_writes & 32'hFFFF);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("%s.data%0d", tag, i), ch_data[i*W +: W], m_data[i]);
    endtask

    // Called at a negedge; applies inputs, models the next rising edge, checks at the following negedge.
    task automatic cycle(input bit v, input logic [2:0] s, input logic [31:0] d,
                         input logic [7:0] a, input bit bc, input bit chk);
        bit rdy;
        bit acc;
        in_valid = v;
        sel      = s;
        in_data  = d;
        ch_ack   = a;
        bcast    = bc;
        #1;
        rdy = m_ready(s, bc);
        if (chk) check_eq("in_ready", 32'(in_ready), 32'(rdy));
        acc = v && rdy;
        @(posedge clk);
        for (int i = 0; i < 8; i++) if (a[i]) m_full[i] = 1'b0;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (bc || s == 3'(i)) begin
                    m_data[i] = d;
                    m_full[i] = 1'b1;
                end
            end
            m_writes++;
        end
        @(negedge clk);
        if (chk) check_state("cyc");
    endtask

    initial begin
        bit bc_r;
        int guard;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sel      = '0;
        in_data  = '0;
        ch_ack   = '0;
        bcast    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_state("reset");
        check_eq("reset.valid_const", 32'(ch_valid), 32'h0);
        rst_n = 1'b1;

        // Single write
        cycle(1, 3'd3, 32'hDEADBEEF, 8'h00, 0, 1);
        check_eq("single.valid", 32'(ch_valid), 32'h08);
        check_eq("single.data3", ch_data[3*W +: W], 32'hDEADBEEF);
        check_eq("single.occ", 32'(occupancy), 32'd1);
        check_eq("single.wrcnt", 32'(wr_count), 32'd1);

        // Back-pressure, then release via ack
        cycle(1, 3'd3, 32'h12345678, 8'h00, 0, 1);
        check_eq("bp.ready", 32'(in_ready), 32'd0);
        check_eq("bp.data3", ch_data[3*W +: W], 32'hDEADBEEF);
        cycle(1, 3'd3, 32'h12345678, 8'h08, 0, 1);
        check_eq("bp.cleared", 32'(ch_valid[3]), 32'd0);
        check_eq("bp.ready_after", 32'(in_ready), 32'd1);
        cycle(1, 3'd3, 32'h12345678, 8'h00, 0, 1);
        check_eq("bp.refill", ch_data[3*W +: W], 32'h12345678);
        cycle(0, 3'd0, 32'h0, 8'h08, 0, 1);

        // Concurrent write and ack on different channels
        cycle(1, 3'd1, 32'h11111111, 8'h00, 0, 1);
        cycle(1, 3'd6, 32'hA5A5A5A5, 8'h02, 0, 1);
        check_eq("conc.valid", 32'(ch_valid), 32'h40);
        check_eq("conc.occ", 32'(occupancy), 32'd1);
        cycle(0, 3'd0, 32'h0, 8'h40, 0, 1);

        // Fill all eight channels
        for (int i = 0; i < 8; i++) cycle(1, 3'(i), 32'h100 + i, 8'h00, 0, 1);
        check_eq("fill.valid", 32'(ch_valid), 32'hFF);
        check_eq("fill.occ", 32'(occupancy), 32'd8);
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            check_eq($sformatf("fill.ready%0d", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        cycle(0, 3'd0, 32'h0, 8'hFF, 0, 1);
        check_eq("drain.occ", 32'(occupancy), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            bc_r = 1'b0;
`ifdef DEMUX_BROADCAST_EN
            bc_r = ($urandom_range(0, 7) == 0);
`endif
            cycle($urandom_range(0, 3) != 0, 3'($urandom), $urandom,
                  8'($urandom & $urandom), bc_r, 1);
        end

        // Asynchronous reset between edges
        cycle(0, 3'd0, 32'h0, 8'hFF, 0, 1);
        cycle(1, 3'd2, 32'h22222222, 8'h00, 0, 1);
        cycle(1, 3'd5, 32'h55555555, 8'h00, 0, 1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst.valid", 32'(ch_valid), 32'h0);
        check_eq("arst.occ", 32'(occupancy), 32'd0);
        check_eq("arst.wrcnt", 32'(wr_count), 32'd0);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("arst.data%0d", i), ch_data[i*W +: W], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_state("post_arst");

`ifdef DEMUX_BROADCAST_EN
        cycle(1, 3'd5, 32'h0BADF00D, 8'h00, 1, 1);
        check_eq("bcast.valid", 32'(ch_valid), 32'hFF);
        check_eq("bcast.occ", 32'(occupancy), 32'd8);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("bcast.data%0d", i), ch_data[i*W +: W], 32'h0BADF00D);
        cycle(0, 3'd0, 32'h0, 8'hEF, 0, 1);
        in_valid = 1'b1;
        bcast    = 1'b1;
        #1;
        check_eq("bcast.blocked", 32'(in_ready), 32'd0);
        @(negedge clk);
        cycle(1, 3'd0, 32'hFFFF0000, 8'h00, 1, 1);
        cycle(0, 3'd0, 32'h0, 8'h10, 0, 1);
`endif

        // Drive writes until the 16-bit counter wraps
        cycle(0, 3'd0, 32'h0, 8'hFF, 0, 1);
        guard = 0;
        while (m_writes < 65536 && guard < 70000) begin
            cycle(1, 3'(m_writes % 8), 32'(m_writes), 8'(1 << ((m_writes + 7) % 8)), 0, 0);
            guard++;
        end
        check_eq("wrap.bound", 32'(m_writes), 32'd65536);
        check_eq("wrap.wrcnt", 32'(wr_count), 32'h0);
        check_state("wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eight_way_result_demux.md
Name: eight_way_result_demux

Overview:
- Write-side counterpart of the 32-bit 8:1 result-select mux in the miniRISC datapath.
- Accepts one 32-bit result per cycle tagged with a 3-bit destination, steers it into one of eight holding registers, and raises that channel's valid flag.
- Each channel is drained independently by its consumer through a per-channel acknowledge.
- A channel that is still occupied back-pressures the producer.

Parameters:
- WIDTH, 32, data width of input and of each channel register.
- CHANNELS, 8, number of output channels; fixed at 8 (SEL is 3 bits); other values unsupported.

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  producer offers IN_DATA for channel SEL.
- IN_READY  output  1  demux can accept on this cycle.
- SEL  input  3  destination channel index 0..7.
- IN_DATA  input  WIDTH  result word.
- CH_DATA  output  8*WIDTH  channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
- CH_VALID  output  8  bit i set while channel i holds unconsumed data.
- CH_ACK  input  8  bit i: consumer of channel i takes its data this cycle.
- OCCUPANCY  output  4  number of set CH_VALID bits, 0..8.
- WR_COUNT  output  16  total accepted writes, wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (RST_N low, asynchronous, any time): CH_DATA all 0, CH_VALID 0x00, OCCUPANCY 0, WR_COUNT 0. In-flight offers are discarded; the producer must re-offer after reset.
- IN_READY is combinational: IN_READY = ~CH_VALID[SEL]. It depends only on registered CH_VALID and the current SEL, never on CH_ACK (no same-cycle pass-through).
- Accept: IN_VALID & IN_READY at a rising edge.
  - Next cycle: CH_DATA[SEL] = IN_DATA, CH_VALID[SEL] = 1, WR_COUNT + 1.
  - Write-to-visible latency is 1 cycle.
- IN_VALID low: no state change from the write side. SEL and IN_DATA are don't-care.
- Blocked offer (IN_VALID=1, IN_READY=0): no state change. The producer holds SEL/IN_DATA, or may change SEL to a free channel next cycle. Changing SEL is legal and ready is re-evaluated.
- Drain: CH_ACK[i] & CH_VALID[i] at an edge clears CH_VALID[i] next cycle.
  - CH_DATA[i] retains the last value (not zeroed).
  - CH_ACK[i] on an empty channel is ignored.
- Multiple channels may be acked in the same cycle.
- Same-channel write + ack in one cycle cannot occur, because IN_READY=0 while occupied. The earliest refill is the cycle after the clearing edge, giving a 2-cycle minimum period per channel.
- Write to channel j with ack of channel k (j != k) in the same cycle: both take effect.
- CH_DATA[i] is stable while CH_VALID[i]=1.
- OCCUPANCY is registered and equals popcount(CH_VALID) at all times. Per cycle it changes by (+1 if accept) - (number of valid acks); range 0..8.
- No FSM beyond the per-channel two-state EMPTY/FULL flags: EMPTY -> FULL on accept, FULL -> EMPTY on ack.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- Defined: adds input port BCAST (1 bit).
  - Offer with BCAST=1: IN_READY = (CH_VALID == 0x00).
  - On accept, all eight CH_DATA load IN_DATA and CH_VALID becomes 0xFF, OCCUPANCY 8, WR_COUNT + 1.
  - SEL is ignored when BCAST=1.
- Not defined: no BCAST port; only single-channel steering exists. Behaviour is otherwise identical.

Test Plan:
- Reset mid-run: fill ch2, ch5, drop RST_N asynchronously between edges -> CH_VALID=0x00, CH_DATA=0, OCCUPANCY=0, WR_COUNT=0 immediately, without waiting for CLK.
- Single write: SEL=3, IN_DATA=0xDEADBEEF, IN_VALID=1 -> next cycle CH_VALID=0x08, CH_DATA[3]=0xDEADBEEF, OCCUPANCY=1, WR_COUNT=1.
- Back-pressure: ch3 full, offer SEL=3 data 0x12345678 -> IN_READY=0, CH_DATA[3] stays 0xDEADBEEF. Assert CH_ACK[3] -> CH_VALID[3]=0 next cycle, IN_READY=1 that cycle, and the offer is accepted one edge later.
- Concurrent: ch1 full, write SEL=6 data 0xA5A5A5A5 with CH_ACK=0x02 same cycle -> CH_VALID=0x40, OCCUPANCY unchanged at 1.
- Fill all: 8 consecutive writes SEL=0..7 data 0x100+i -> CH_VALID=0xFF, OCCUPANCY=8, every IN_READY=0. Ack 0xFF -> OCCUPANCY=0. Then drive 65536 total writes -> WR_COUNT wraps to 0x0000.
- Broadcast (DEMUX_BROADCAST_EN): with all empty, BCAST=1 data 0x0BADF00D -> all channels 0x0BADF00D, CH_VALID=0xFF. BCAST offer with ch4 still full -> IN_READY=0.
